regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (WE3/A3/WD3) among NREQ writeback requesters, e.g. ALU, load unit and multiplier.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning write one cycle before it reaches the register file.
- Flags same-cycle read-after-write hazards so the datapath can forward data.
- Sits between the execute/memory writeback sources and register_file.

---
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file's single write port among NREQ writeback sources.
// Optional per-requester stall counters (stall_cnt, perf_clr) are enabled with `define WB_ARB_PERF_EN.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               wb_stall,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               WE3,
  output logic [AW-1:0]      A3,
  output logic [DW-1:0]      WD3,
  input  logic [AW-1:0]      A1,
  input  logic [AW-1:0]      A2,
  output logic               fwd1,
  output logic               fwd2
`ifdef WB_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0] stall_cnt,
  input  logic               perf_clr
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] winner;
  logic          found;
  logic          xfer;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  // Requester index k positions after base, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[PW-1:0];
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[rr_idx(rr_ptr, k)]) begin
        found  = 1'b1;
        winner = rr_idx(rr_ptr, k);
      end
    end
  end

  // Grants are suppressed while stalled and while reset is asserted.
  assign xfer = found & ~wb_stall & rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[winner] = 1'b1;
  end

  assign win_addr = req_addr[int'(winner)*AW +: AW];
  assign win_data = req_data[int'(winner)*DW +: DW];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      WE3    <= 1'b0;
      A3     <= '0;
      WD3    <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      WE3    <= (win_addr != '0);
      A3     <= win_addr;
      WD3    <= win_data;
      rr_ptr <= rr_idx(winner, 1);
    end else begin
      WE3    <= 1'b0;
    end
  end

  // Same-cycle read-after-write: the read port must bypass the array and take WD3.
  assign fwd1 = rst & WE3 & (A3 == A1) & (A1 != '0);
  assign fwd2 = rst & WE3 & (A3 == A2) & (A2 != '0);

`ifdef WB_ARB_PERF_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_perf
    logic [15:0] cnt;
    always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
        cnt <= '0;
      end else if (perf_clr) begin
        cnt <= '0;
      end else if (req_valid[i] && !req_ready[i] && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
    assign stall_cnt[i*16 +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter (NREQ=3, AW=5, DW=32); stall counters are
// exercised too when WB_ARB_PERF_EN is defined.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               CLK;
  logic               rst;
  logic               wb_stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               WE3;
  logic [AW-1:0]      A3;
  logic [DW-1:0]      WD3;
  logic [AW-1:0]      A1;
  logic [AW-1:0]      A2;
  logic               fwd1;
  logic               fwd2;
`ifdef WB_ARB_PERF_EN
  logic [NREQ*16-1:0] stall_cnt;
  logic               perf_clr;
`endif

  int vectors    = 0;
  int miscompares = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .wb_stall  (wb_stall),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .A1        (A1),
    .A2        (A2),
    .fwd1      (fwd1),
    .fwd2      (fwd2)
`ifdef WB_ARB_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .perf_clr  (perf_clr)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b0; wb_stall = 1'b0; req_valid = 3'b111;
    req_addr = '0; req_data = '0; A1 = '0; A2 = '0;
`ifdef WB_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    #3;
    check("rst_we3",   WE3, 0);
    check("rst_a3",    A3, 0);
    check("rst_wd3",   WD3, 0);
    check("rst_ready", req_ready, 0);

    // Release reset with nothing valid.
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick(); tick();
    check("idle_we3",   WE3, 0);
    check("idle_a3",    A3, 0);
    check("idle_ready", req_ready, 0);

    // Single write from requester 1 (rr_ptr 0 -> 2).
    set_req(1, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1 check("single_ready", req_ready, 3'b010);
    tick();
    check("single_we3", WE3, 1);
    check("single_a3",  A3, 5);
    check("single_wd3", WD3, 32'hDEADBEEF);
    req_valid = '0;
    tick();
    check("single_we3_off", WE3, 0);
    check("single_a3_hold", A3, 5);

    // Requester 2 write moves rr_ptr back to 0.
    set_req(2, 5'd9, 32'h0000_0009);
    req_valid = 3'b100;
    #1 check("r2_ready", req_ready, 3'b100);
    tick();
    check("r2_a3", A3, 9);

    // Round robin with all three valid: grants 0,1,2,0,1,2.
    set_req(0, 5'd1, 32'd100);
    set_req(1, 5'd2, 32'd200);
    set_req(2, 5'd3, 32'd300);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      logic [2:0] exp_ready;
      exp_ready = 3'b001 << (c % 3);
      #1 check($sformatf("rr_ready_%0d", c), req_ready, exp_ready);
      tick();
      check($sformatf("rr_we3_%0d", c), WE3, 1);
      check($sformatf("rr_a3_%0d", c),  A3, (c % 3) + 1);
    end
    req_valid = '0;

    // Write to x0 is accepted but discarded; rr_ptr still advances to 1.
    set_req(0, 5'd0, 32'h1234);
    req_valid = 3'b001;
    #1 check("x0_ready", req_ready, 3'b001);
    tick();
    check("x0_we3", WE3, 0);
    check("x0_a3",  A3, 0);
    check("x0_wd3", WD3, 32'h1234);
    req_valid = 3'b111;
    #1 check("x0_rr_next", req_ready, 3'b010);
    req_valid = '0;
    tick();
    check("x0_idle_we3", WE3, 0);

    // Stall blocks grants for four cycles; dropping it grants requester 2.
    set_req(2, 5'd7, 32'hCAFE0007);
    req_valid = 3'b100;
    wb_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check($sformatf("stall_ready_%0d", c), req_ready, 0);
      tick();
      check($sformatf("stall_we3_%0d", c), WE3, 0);
    end
    wb_stall = 1'b0;
    #1 check("unstall_ready", req_ready, 3'b100);
    tick();
    check("unstall_we3", WE3, 1);
    check("unstall_a3",  A3, 7);
    check("unstall_wd3", WD3, 32'hCAFE0007);

    // Registered write still issues under stall; check forwarding flags.
    req_valid = '0;
    wb_stall = 1'b1;
    A1 = 5'd7; A2 = 5'd0;
    #1;
    check("stall_keeps_we3", WE3, 1);
    check("fwd1_hit", fwd1, 1);
    check("fwd2_x0",  fwd2, 0);
    A1 = 5'd3; A2 = 5'd7;
    #1;
    check("fwd1_miss", fwd1, 0);
    check("fwd2_hit",  fwd2, 1);
    wb_stall = 1'b0;
    tick();
    check("fwd_after_we3_off", fwd2, 0);
    A1 = '0; A2 = '0;

    // Mid-operation reset kills the pending write and rr_ptr.
    set_req(0, 5'd4, 32'd44);
    req_valid = 3'b001;
    tick();
    check("pre_rst_we3", WE3, 1);
    req_valid = '0;
    A1 = 5'd4;
    #1 rst = 1'b0;
    #1;
    check("midrst_we3",  WE3, 0);
    check("midrst_a3",   A3, 0);
    check("midrst_wd3",  WD3, 0);
    check("midrst_fwd1", fwd1, 0);
    @(negedge CLK);
    rst = 1'b1;
    A1 = '0;
    tick();
    req_valid = 3'b011;
    #1 check("post_rst_rr0", req_ready, 3'b001);
    req_valid = '0;
    tick();

`ifdef WB_ARB_PERF_EN
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    wb_stall = 1'b1;
    req_valid = 3'b010;
    tick(); tick(); tick();
    req_valid = '0;
    wb_stall = 1'b0;
    #1;
    check("perf_cnt1", stall_cnt[16 +: 16], 3);
    check("perf_cnt0", stall_cnt[0 +: 16], 0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("perf_clr", stall_cnt[16 +: 16], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
